// File: rtl/mult_dot_accumulator.sv
// Dot-product accumulator behind the 8x8 multiplier: sums LEN products and then holds the result on a valid/ready port.
// Optional feature macro MULT_DOT_ACC_SATURATE_EN: when defined, overflow clamps the accumulator at all-ones instead of letting it wrap.
module mult_dot_accumulator #(
   parameter int ACC_W = 24,
   parameter int LEN   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      prod,
   input  logic             prod_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             out_err,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   localparam logic [7:0] LEN_C = 8'(LEN);

   state_t           r_state;
   logic [ACC_W-1:0] r_acc;
   logic [7:0]       r_cnt;
   logic             r_err;

   logic             w_accept;
   logic [ACC_W:0]   w_sum;
   logic             w_ovf;
   logic [ACC_W-1:0] w_acc_next;
   logic [7:0]       w_cnt_inc;
   logic             w_last;

   assign w_accept  = in_valid && in_ready;
   assign w_sum     = {1'b0, r_acc} + {{(ACC_W-15){1'b0}}, prod};
   assign w_ovf     = w_sum[ACC_W];
   assign w_cnt_inc = r_cnt + 8'd1;
   assign w_last    = (w_cnt_inc == LEN_C);

`ifdef MULT_DOT_ACC_SATURATE_EN
   // Once clamped, adding a non-zero term overflows again, so the accumulator stays at all-ones.
   assign w_acc_next = w_ovf ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
   assign w_acc_next = w_sum[ACC_W-1:0];
`endif

   // NOTE: acc/cnt/err are deliberately left untouched when a result is handed off; only the first term of the next run reloads them.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_acc   <= {{(ACC_W-16){1'b0}}, prod};
                  r_cnt   <= 8'd1;
                  r_err   <= prod_cout;
                  r_state <= (LEN_C == 8'd1) ? S_HOLD : S_ACCUM;
               end
            end
            S_ACCUM: begin
               if (w_accept) begin
                  r_acc <= w_acc_next;
                  r_cnt <= w_cnt_inc;
                  r_err <= r_err | prod_cout | w_ovf;
                  if (w_last) begin
                     r_state <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state != S_HOLD);
   assign out_valid = (r_state == S_HOLD);
   assign busy      = (r_state == S_ACCUM);
   assign acc_out   = r_acc;
   assign out_err   = r_err;

endmodule

// File: tb/tb_mult_dot_accumulator.sv
// Self-checking bench for mult_dot_accumulator: four configurations checked every cycle against a sum-of-terms model.
// Honours MULT_DOT_ACC_SATURATE_EN for the expected overflow behaviour.
module tb_mult_dot_accumulator;

   localparam int NI = 4;

`ifdef MULT_DOT_ACC_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   // Instance configurations: 0 = (24,4), 1 = (17,4), 2 = (24,8), 3 = (24,1)
   function automatic int accw_of(input int g);
      return (g == 1) ? 17 : 24;
   endfunction

   function automatic int len_of(input int g);
      case (g)
         2:       return 8;
         3:       return 1;
         default: return 4;
      endcase
   endfunction

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        in_valid_v  [NI];
   logic        cout_v      [NI];
   logic        out_ready_v [NI];
   logic [15:0] prod_v      [NI];
   logic        in_ready_v  [NI];
   logic        out_valid_v [NI];
   logic        out_err_v   [NI];
   logic        busy_v      [NI];
   logic [31:0] acc_v       [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      logic [accw_of(g)-1:0] w_acc;
      mult_dot_accumulator #(
         .ACC_W(accw_of(g)),
         .LEN  (len_of(g))
      ) u_dut (
         .clk      (clk),
         .rst      (rst),
         .in_valid (in_valid_v[g]),
         .in_ready (in_ready_v[g]),
         .prod     (prod_v[g]),
         .prod_cout(cout_v[g]),
         .out_valid(out_valid_v[g]),
         .out_ready(out_ready_v[g]),
         .acc_out  (w_acc),
         .out_err  (out_err_v[g]),
         .busy     (busy_v[g])
      );
      assign acc_v[g] = 32'(w_acc);
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the true arithmetic sum of accepted terms, how many were taken, and whether a result is waiting.
   longint m_sum  [NI];
   int     m_n    [NI];
   bit     m_cout [NI];
   bit     m_hold [NI];
   bit     m_live = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_live <= 1'b1;
         for (int g = 0; g < NI; g++) begin
            m_sum[g]  <= 0;
            m_n[g]    <= 0;
            m_cout[g] <= 1'b0;
            m_hold[g] <= 1'b0;
         end
      end else begin
         for (int g = 0; g < NI; g++) begin
            if (m_hold[g]) begin
               if (out_ready_v[g] === 1'b1) begin
                  m_hold[g] <= 1'b0;
                  m_n[g]    <= 0;
                  m_sum[g]  <= 0;
                  m_cout[g] <= 1'b0;
               end
            end else if (in_valid_v[g] === 1'b1) begin
               m_sum[g]  <= m_sum[g] + longint'(prod_v[g]);
               m_cout[g] <= m_cout[g] | cout_v[g];
               m_n[g]    <= m_n[g] + 1;
               m_hold[g] <= (m_n[g] + 1 == len_of(g));
            end
         end
      end
   end

   function automatic longint max_of(input int g);
      return (longint'(1) << accw_of(g)) - 1;
   endfunction

   function automatic longint exp_acc(input int g);
      if (SAT) return (m_sum[g] > max_of(g)) ? max_of(g) : m_sum[g];
      return m_sum[g] & max_of(g);
   endfunction

   function automatic bit exp_err(input int g);
      return m_cout[g] | (m_sum[g] > max_of(g));
   endfunction

   // Per-cycle comparison of every instance against the model.
   always @(negedge clk) begin
      if (m_live) begin
         for (int g = 0; g < NI; g++) begin
            check($sformatf("in_ready[%0d]", g), 64'(in_ready_v[g]), 64'(!m_hold[g]));
            check($sformatf("out_valid[%0d]", g), 64'(out_valid_v[g]), 64'(m_hold[g]));
            check($sformatf("busy[%0d]", g), 64'(busy_v[g]), 64'((m_n[g] > 0) && !m_hold[g]));
            if (m_hold[g]) begin
               check($sformatf("acc_out[%0d]", g), 64'(acc_v[g]), 64'(exp_acc(g)));
               check($sformatf("out_err[%0d]", g), 64'(out_err_v[g]), 64'(exp_err(g)));
            end
         end
      end
   end

   // Offers one term and returns #1 after the edge that accepted it.
   task automatic send(input int g, input logic [15:0] p, input logic c);
      bit ok;
      bit rdy;
      ok = 1'b0;
      in_valid_v[g] = 1'b1;
      prod_v[g]     = p;
      cout_v[g]     = c;
      for (int k = 0; k < 64; k++) begin
         rdy = !m_hold[g];
         @(posedge clk);
         #1;
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      in_valid_v[g] = 1'b0;
      check("send_accept_timeout", 64'(ok), 64'd1);
   endtask

   // Waits for a held result, keeps out_ready low for 'delay' cycles, then takes it.
   task automatic take(input int g, input int delay);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 64; k++) begin
         if (m_hold[g]) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      check("take_hold_timeout", 64'(ok), 64'd1);
      repeat (delay) begin
         @(posedge clk);
         #1;
      end
      out_ready_v[g] = 1'b1;
      @(posedge clk);
      #1;
      out_ready_v[g] = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      for (int g = 0; g < NI; g++) begin
         in_valid_v[g]  = 1'b0;
         cout_v[g]      = 1'b0;
         out_ready_v[g] = 1'b0;
         prod_v[g]      = 16'h0;
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset values on every instance
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
         check("rst_in_ready", 64'(in_ready_v[g]), 64'd1);
         check("rst_out_valid", 64'(out_valid_v[g]), 64'd0);
         check("rst_acc_out", 64'(acc_v[g]), 64'd0);
         check("rst_out_err", 64'(out_err_v[g]), 64'd0);
         check("rst_busy", 64'(busy_v[g]), 64'd0);
      end
      @(posedge clk);
      #1;

      // Four 255x255 products, back-to-back, 24-bit accumulator
      send(0, 16'hFE01, 1'b0);
      check("t1_busy_after_first", 64'(busy_v[0]), 64'd1);
      for (int i = 0; i < 3; i++) send(0, 16'hFE01, 1'b0);
      check("t1_out_valid", 64'(out_valid_v[0]), 64'd1);
      check("t1_busy_low", 64'(busy_v[0]), 64'd0);
      check("t1_acc", 64'(acc_v[0]), 64'h03F804);
      check("t1_err", 64'(out_err_v[0]), 64'd0);
      take(0, 0);

      // Same terms into a 17-bit accumulator: overflow on the 3rd term
      for (int i = 0; i < 4; i++) send(1, 16'hFE01, 1'b0);
      check("t2_acc", 64'(acc_v[1]), SAT ? 64'h1FFFF : 64'h1F804);
      check("t2_err", 64'(out_err_v[1]), 64'd1);
      take(1, 0);

      // Terms 1..8 with five cycles of back-pressure and a term offered during HOLD
      for (int i = 1; i <= 8; i++) send(2, 16'(i), 1'b0);
      in_valid_v[2] = 1'b1;
      prod_v[2]     = 16'h0055;
      cout_v[2]     = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t3_acc_stable", 64'(acc_v[2]), 64'd36);
         check("t3_in_ready_low", 64'(in_ready_v[2]), 64'd0);
         check("t3_out_valid", 64'(out_valid_v[2]), 64'd1);
      end
      in_valid_v[2]  = 1'b0;
      out_ready_v[2] = 1'b1;
      @(posedge clk);
      #1;
      out_ready_v[2] = 1'b0;
      @(negedge clk);
      check("t3_released", 64'(out_valid_v[2]), 64'd0);
      check("t3_not_consumed", 64'(busy_v[2]), 64'd0);
      @(posedge clk);
      #1;

      // Carry-out on the second term sets the error; the next result is clean
      send(0, 16'h0001, 1'b0);
      send(0, 16'h0001, 1'b1);
      send(0, 16'h0001, 1'b0);
      send(0, 16'h0001, 1'b0);
      check("t4_acc", 64'(acc_v[0]), 64'd4);
      check("t4_err", 64'(out_err_v[0]), 64'd1);
      take(0, 1);
      for (int i = 0; i < 4; i++) send(0, 16'h0002, 1'b0);
      check("t4b_acc", 64'(acc_v[0]), 64'd8);
      check("t4b_err", 64'(out_err_v[0]), 64'd0);
      take(0, 0);

      // Reset in the middle of a run discards the partial sum
      send(0, 16'h1111, 1'b1);
      send(0, 16'h2222, 1'b0);
      pulse_reset();
      @(negedge clk);
      check("t5_in_ready", 64'(in_ready_v[0]), 64'd1);
      check("t5_out_valid", 64'(out_valid_v[0]), 64'd0);
      check("t5_busy", 64'(busy_v[0]), 64'd0);
      check("t5_acc", 64'(acc_v[0]), 64'd0);
      check("t5_err", 64'(out_err_v[0]), 64'd0);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) send(0, 16'h0010, 1'b0);
      check("t5_acc_after", 64'(acc_v[0]), 64'h40);
      check("t5_err_after", 64'(out_err_v[0]), 64'd0);
      take(0, 0);

      // Single-term dot product
      send(3, 16'h1234, 1'b0);
      check("t6_out_valid", 64'(out_valid_v[3]), 64'd1);
      check("t6_acc", 64'(acc_v[3]), 64'h001234);
      check("t6_busy", 64'(busy_v[3]), 64'd0);
      take(3, 2);

      // Randomized runs on every configuration, checked by the per-cycle model compare
      for (int g = 0; g < NI; g++) begin
         for (int r = 0; r < 25; r++) begin
            for (int t = 0; t < len_of(g); t++) begin
               logic [15:0] p;
               logic        c;
               if ($urandom_range(3) == 0) begin
                  repeat ($urandom_range(3)) begin
                     @(posedge clk);
                     #1;
                  end
               end
               p = ($urandom_range(1) == 0) ? 16'($urandom) : 16'($urandom_range(255));
               c = ($urandom_range(15) == 0);
               send(g, p, c);
            end
            take(g, int'($urandom_range(3)));
         end
      end

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
